// File: rtl/regfile_pkg.sv
// Shared types, defaults and helpers for the multi-port integer register file.
// Optional same-cycle write bypass is selected with REGFILE_BYPASS_EN.
package regfile_pkg;

    localparam int unsigned XLEN_DEF     = 32;
    localparam int unsigned NUM_REGS_DEF = 32;

    typedef enum logic {
        CLEAR,
        RUN
    } st_e;

    // True when addr names an existing register (handles non power-of-two counts).
    function automatic logic rf_in_range(input logic [31:0] addr, input int unsigned n);
        return addr < n;
    endfunction

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: zero/range/ready gating plus optional WB bypass.
// Bypass path exists only when REGFILE_BYPASS_EN is defined.
module rf_read_port
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN     = XLEN_DEF,
    parameter int unsigned NUM_REGS = NUM_REGS_DEF,
    parameter int unsigned AW       = $clog2(NUM_REGS)
) (
`ifdef REGFILE_BYPASS_EN
    input  logic            byp_en,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
`endif
    input  logic            ready,
    input  logic [AW-1:0]   raddr,
    input  logic [XLEN-1:0] regs [NUM_REGS],
    output logic [XLEN-1:0] rdata_c
);

    always_comb begin
        rdata_c = '0;
        if (ready && (raddr != '0) && rf_in_range(32'(raddr), NUM_REGS)) begin
            rdata_c = regs[raddr];
`ifdef REGFILE_BYPASS_EN
            if (byp_en && (raddr == waddr)) begin
                rdata_c = wdata;
            end
`endif
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised ID-stage register file with post-reset clear sequencer and ready handshake.
// Define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN     = XLEN_DEF,
    parameter int unsigned NUM_REGS = NUM_REGS_DEF,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned AW       = $clog2(NUM_REGS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_RD*AW-1:0]   raddr,
    output logic [NUM_RD*XLEN-1:0] rdata,
    input  logic                   we,
    input  logic [AW-1:0]          waddr,
    input  logic [XLEN-1:0]        wdata,
    output logic                   ready,
    input  logic                   clr_req
);

    localparam logic [AW-1:0] LAST_IDX = AW'(NUM_REGS - 1);

    st_e             state_q, state_d;
    logic [AW-1:0]   clr_idx_q, clr_idx_d;
    logic            ready_q, ready_d;

    logic [XLEN-1:0] mem_q [NUM_REGS];
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [XLEN-1:0] wr_data;
    logic            wr_ok;

    assign wr_ok = we && ready_q && (waddr != '0) && rf_in_range(32'(waddr), NUM_REGS);
    assign ready = ready_q;

    // Clear sequencer and write-port arbitration; clear has priority over WB writes.
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        ready_d   = ready_q;
        wr_en     = 1'b0;
        wr_addr   = waddr;
        wr_data   = wdata;
        case (state_q)
            CLEAR: begin
                wr_en     = 1'b1;
                wr_addr   = clr_idx_q;
                wr_data   = '0;
                clr_idx_d = clr_idx_q + AW'(1);
                if (clr_idx_q == LAST_IDX) begin
                    ready_d = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (clr_req) begin
                    state_d   = CLEAR;
                    clr_idx_d = AW'(1);
                    ready_d   = 1'b0;
                end else if (wr_ok) begin
                    wr_en = 1'b1;
                end
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= CLEAR;
            clr_idx_q <= AW'(1);
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            ready_q   <= ready_d;
        end
    end

    // Storage is deliberately not reset; the clear sequence zeroes it before ready.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic byp_en;
    assign byp_en = wr_ok;
`endif

    for (genvar i = 0; i < int'(NUM_RD); i++) begin : g_rd
        rf_read_port #(
            .XLEN     (XLEN),
            .NUM_REGS (NUM_REGS),
            .AW       (AW)
        ) u_rd (
`ifdef REGFILE_BYPASS_EN
            .byp_en   (byp_en),
            .waddr    (waddr),
            .wdata    (wdata),
`endif
            .ready    (ready_q),
            .raddr    (raddr[i*AW +: AW]),
            .regs     (mem_q),
            .rdata_c  (rdata[i*XLEN +: XLEN])
        );
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: a 32x2 instance and a 24x3 instance driven in parallel.
module tb_regfile_mp;

    logic        clk;
    logic [9:0]  raddr0;
    logic [63:0] rdata0;
    logic        ready0;
    logic [14:0] raddr1;
    logic [95:0] rdata1;
    logic        ready1;

    logic [4:0]  ra [2][4];
    logic        rst_t [2];
    logic        we_t [2];
    logic [4:0]  wa [2];
    logic [31:0] wd [2];
    logic        clr_t [2];

    assign raddr0 = {ra[0][1], ra[0][0]};
    assign raddr1 = {ra[1][2], ra[1][1], ra[1][0]};

    regfile_mp #(.XLEN(32), .NUM_REGS(32), .NUM_RD(2)) dut (
        .clk(clk), .reset(rst_t[0]), .raddr(raddr0), .rdata(rdata0),
        .we(we_t[0]), .waddr(wa[0]), .wdata(wd[0]), .ready(ready0), .clr_req(clr_t[0])
    );

    regfile_mp #(.XLEN(32), .NUM_REGS(24), .NUM_RD(3)) dut24 (
        .clk(clk), .reset(rst_t[1]), .raddr(raddr1), .rdata(rdata1),
        .we(we_t[1]), .waddr(wa[1]), .wdata(wd[1]), .ready(ready1), .clr_req(clr_t[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: register contents, ready flag and edges left until ready.
    logic [31:0] m_reg [2][64];
    bit          m_ready [2];
    int          m_left [2];
    int          nregs [2] = '{32, 24};
    int          nrd [2]   = '{2, 3};

    typedef struct {
        int          inst;
        bit          rdy;
        logic [31:0] rd [4];
        string       tag;
    } exp_t;

    exp_t  q [$];
    int    n_cmp;
    int    n_bad;
    string tag;

    function automatic logic [31:0] exp_read(int k, logic [4:0] a);
        if (rst_t[k] || !m_ready[k] || a == 5'd0 || int'(a) >= nregs[k]) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (we_t[k] && wa[k] != 5'd0 && int'(wa[k]) < nregs[k] && a == wa[k]) return wd[k];
`endif
        return m_reg[k][a];
    endfunction

    function automatic void start_clear(int k);
        m_ready[k] = 1'b0;
        m_left[k]  = nregs[k] - 1;
        for (int r = 0; r < 64; r++) m_reg[k][r] = 32'h0;
    endfunction

    function automatic void model_edge(int k);
        if (rst_t[k]) begin
            start_clear(k);
        end else if (!m_ready[k]) begin
            m_left[k]--;
            if (m_left[k] == 0) m_ready[k] = 1'b1;
        end else if (clr_t[k]) begin
            start_clear(k);
        end else if (we_t[k] && wa[k] != 5'd0 && int'(wa[k]) < nregs[k]) begin
            m_reg[k][wa[k]] = wd[k];
        end
    endfunction

    // Issue the current inputs for one cycle: queue expectations, then advance the model.
    task automatic cycle();
        for (int k = 0; k < 2; k++) begin
            exp_t e;
            e.inst = k;
            e.rdy  = m_ready[k] && !rst_t[k];
            for (int p = 0; p < 4; p++)
                e.rd[p] = (p < nrd[k]) ? exp_read(k, ra[k][p]) : 32'h0;
            e.tag = tag;
            q.push_back(e);
        end
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
    endtask

    task automatic rand_reads();
        for (int k = 0; k < 2; k++)
            for (int p = 0; p < 4; p++)
                ra[k][p] = 5'($urandom_range(0, 31));
    endtask

    task automatic idle_all();
        for (int k = 0; k < 2; k++) begin
            rst_t[k] = 1'b0;
            we_t[k]  = 1'b0;
            clr_t[k] = 1'b0;
            wa[k]    = 5'd0;
            wd[k]    = 32'h0;
        end
    endtask

    // Monitor: outputs are combinational, so every queued expectation is checked mid-cycle.
    always @(negedge clk) begin : mon
        exp_t        e;
        logic [31:0] g;
        logic        gr;
        while (q.size() != 0) begin
            e  = q.pop_front();
            gr = (e.inst == 0) ? ready0 : ready1;
            n_cmp++;
            if (gr !== e.rdy) begin
                n_bad++;
                $display("FAIL %s inst%0d ready: got %b expected %b @%0t", e.tag, e.inst, gr, e.rdy, $time);
            end
            for (int p = 0; p < nrd[e.inst]; p++) begin
                g = (e.inst == 0) ? rdata0[p*32 +: 32] : rdata1[p*32 +: 32];
                n_cmp++;
                if (g !== e.rd[p]) begin
                    n_bad++;
                    $display("FAIL %s inst%0d rdata%0d: got %h expected %h @%0t",
                             e.tag, e.inst, p, g, e.rd[p], $time);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        n_cmp = 0;
        n_bad = 0;
        idle_all();
        rand_reads();
        rst_t[0] = 1'b1;
        rst_t[1] = 1'b1;
        start_clear(0);
        start_clear(1);
        @(posedge clk);
        #1;

        tag = "reset";
        we_t[0] = 1'b1; wa[0] = 5'd5; wd[0] = 32'hdeadbeef;
        repeat (2) begin rand_reads(); cycle(); end
        idle_all();

        tag = "clear";
        for (int c = 0; c < 40; c++) begin
            rand_reads();
            we_t[0]  = (c == 3);
            wa[0]    = 5'd5;
            wd[0]    = 32'hdeadbeef;
            rst_t[1] = (c == 10);
            we_t[1]  = (c == 5);
            wa[1]    = 5'd3;
            wd[1]    = 32'h0badf00d;
            cycle();
        end
        idle_all();

        tag = "x5_after_ready";
        ra[0][0] = 5'd5; ra[0][1] = 5'd5;
        cycle();

        tag = "wr_x1";
        rand_reads();
        we_t[0] = 1'b1; wa[0] = 5'd1; wd[0] = 32'hdeadbeef;
        cycle();
        we_t[0] = 1'b0;
        tag = "rd_x0_x1";
        ra[0][0] = 5'd0; ra[0][1] = 5'd1;
        cycle();

        tag = "wr_x0";
        we_t[0] = 1'b1; wa[0] = 5'd0; wd[0] = 32'hffffffff;
        ra[0][0] = 5'd0; ra[0][1] = 5'd0;
        cycle();
        we_t[0] = 1'b0;
        cycle();

        tag = "same_cycle_x7";
        we_t[0] = 1'b1; wa[0] = 5'd7; wd[0] = 32'h12345678;
        ra[0][0] = 5'd1; ra[0][1] = 5'd7;
        cycle();
        we_t[0] = 1'b0;
        tag = "after_x7";
        cycle();

        tag = "fill";
        for (int i = 1; i < 32; i++) begin
            rand_reads();
            we_t[0] = 1'b1; wa[0] = 5'(i); wd[0] = 32'(i) * 32'h01010101;
            cycle();
        end
        we_t[0] = 1'b0;
        tag = "readback";
        for (int i = 0; i < 32; i += 2) begin
            ra[0][0] = 5'(i); ra[0][1] = 5'(i + 1);
            cycle();
        end

        tag = "clr_req";
        clr_t[0] = 1'b1; we_t[0] = 1'b1; wa[0] = 5'd9; wd[0] = 32'hcafef00d;
        ra[0][0] = 5'd9; ra[0][1] = 5'd31;
        cycle();
        idle_all();
        tag = "reclear";
        for (int c = 0; c < 34; c++) begin rand_reads(); cycle(); end
        tag = "cleared_readback";
        for (int i = 0; i < 32; i += 2) begin
            ra[0][0] = 5'(i); ra[0][1] = 5'(i + 1);
            cycle();
        end

        tag = "oor_24";
        we_t[1] = 1'b1; wa[1] = 5'd30; wd[1] = 32'h55aa55aa;
        ra[1][0] = 5'd30; ra[1][1] = 5'd30; ra[1][2] = 5'd6;
        cycle();
        we_t[1] = 1'b0;
        cycle();
        tag = "last_24";
        we_t[1] = 1'b1; wa[1] = 5'd23; wd[1] = 32'h87654321;
        ra[1][0] = 5'd23; ra[1][1] = 5'd24; ra[1][2] = 5'd7;
        cycle();
        we_t[1] = 1'b0;
        cycle();

        tag = "random";
        for (int c = 0; c < 400; c++) begin
            rand_reads();
            for (int k = 0; k < 2; k++) begin
                we_t[k]  = 1'($urandom_range(0, 1));
                wa[k]    = 5'($urandom_range(0, 31));
                wd[k]    = $urandom;
                clr_t[k] = ($urandom_range(0, 59) == 0);
                rst_t[k] = ($urandom_range(0, 199) == 0);
            end
            if ($urandom_range(0, 3) == 0) ra[0][1] = wa[0];
            if ($urandom_range(0, 3) == 0) ra[1][2] = wa[1];
            cycle();
        end
        idle_all();
        tag = "tail";
        rand_reads();
        cycle();

        @(negedge clk);
        #1;
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL queue_drain: got %0d pending expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
